// File: rtl/comp_mult_pkg.sv
// Shared types and width helpers for the complex-multiplier arbiter.
// Optional build macro: CMARB_FIXED_PRIO_EN (fixed-priority arbitration).
package comp_mult_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  // Operand bus: {x1, y1, x2, y2}, each dw bits.
  function automatic int unsigned op_width(input int unsigned dw);
    return 4 * dw;
  endfunction

  // Result bus: {xr, yr}, each 2*dw+2 bits.
  function automatic int unsigned res_width(input int unsigned dw);
    return 4 * (dw + 1);
  endfunction

  // Owner-ID width, kept at least one bit so a single requester still builds.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, with wrap.
// With CMARB_FIXED_PRIO_EN defined the search always starts at 0 (lowest index wins).
module rr_arbiter
  import comp_mult_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   req_i,
  input  logic [IdW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IdW-1:0] gnt_id_o
);

  logic [IdW-1:0] base;

`ifdef CMARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
  assign base       = '0;
`else
  assign base = ptr_i;
`endif

  // Scan N positions starting from base; the first asserted request wins.
  always_comb begin
    logic         found;
    logic [IdW:0] idx;
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = {1'b0, base} + (IdW + 1)'(k);
      if (idx >= (IdW + 1)'(N)) idx = idx - (IdW + 1)'(N);
      if (!found && req_i[idx[IdW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[idx[IdW-1:0]]    = 1'b1;
        gnt_id_o               = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/comp_mult_arb.sv
// Shares one complex multiplier among NREQ val/rdy requesters, one transaction
// in flight at a time; results are routed back only to the issuing requester.
// Optional build macro: CMARB_FIXED_PRIO_EN (fixed priority, rr_ptr held at 0).
module comp_mult_arb
  import comp_mult_pkg::*;
#(
  parameter  int unsigned DWIDTH = 8,
  parameter  int unsigned NREQ   = 4,
  localparam int unsigned IDW    = id_width(NREQ),
  localparam int unsigned OpW    = op_width(DWIDTH),
  localparam int unsigned ResW   = res_width(DWIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sw_rst_i,
  input  logic [NREQ-1:0]      req_val_i,
  output logic [NREQ-1:0]      req_rdy_o,
  input  logic [NREQ*OpW-1:0]  req_data_i,
  output logic [NREQ-1:0]      rsp_val_o,
  input  logic [NREQ-1:0]      rsp_rdy_i,
  output logic [ResW-1:0]      rsp_data_o,
  output logic                 mult_op_val_o,
  input  logic                 mult_op_rdy_i,
  output logic [OpW-1:0]       mult_op_data_o,
  input  logic                 mult_res_val_i,
  output logic                 mult_res_rdy_o,
  input  logic [ResW-1:0]      mult_res_data_i,
  output logic [IDW-1:0]       owner_o,
  output logic                 busy_o
);

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [OpW-1:0] op_buf_q, op_buf_d;

  logic [NREQ-1:0]         arb_gnt;
  logic [IDW-1:0]          arb_id;
  logic [NREQ-1:0][OpW-1:0] req_data_arr;

  assign req_data_arr = req_data_i;

  rr_arbiter #(
    .N   (NREQ),
    .IdW (IDW)
  ) u_arb (
    .req_i    (req_val_i),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id)
  );

  // Next-state: grant in IDLE, hand operands over in ISSUE, pass result in WAIT.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    op_buf_d = op_buf_q;
    unique case (state_q)
      StIdle: begin
        if (|req_val_i) begin
          state_d  = StIssue;
          op_buf_d = req_data_arr[arb_id];
          owner_d  = arb_id;
`ifdef CMARB_FIXED_PRIO_EN
          rr_ptr_d = '0;
`else
          rr_ptr_d = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
`endif
        end
      end
      StIssue: begin
        if (mult_op_rdy_i) state_d = StWait;
      end
      StWait: begin
        if (mult_res_val_i && rsp_rdy_i[owner_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; sw_rst_i clears everything synchronously, dropping any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_buf_q <= '0;
    end else if (sw_rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      op_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      op_buf_q <= op_buf_d;
    end
  end

  // Handshake outputs; held low while sw_rst_i is asserted so nothing is accepted then.
  always_comb begin
    req_rdy_o      = '0;
    rsp_val_o      = '0;
    rsp_data_o     = '0;
    mult_res_rdy_o = 1'b0;
    mult_op_val_o  = (state_q == StIssue) && !sw_rst_i;
    mult_op_data_o = op_buf_q;
    owner_o        = owner_q;
    busy_o         = (state_q != StIdle);
    if (!sw_rst_i) begin
      if (state_q == StIdle) req_rdy_o = arb_gnt;
      if (state_q == StWait) begin
        rsp_val_o[owner_q] = mult_res_val_i;
        mult_res_rdy_o     = rsp_rdy_i[owner_q];
        rsp_data_o         = mult_res_data_i;
      end
    end
  end

endmodule
